// File: rtl/q_table_updater.sv
// q_table_updater
//   Writer-side companion to the Q-value action selector. For one taken
//   action it reads the current-state row and the next-state row, computes
//   Q <= Q + alpha*(r + gamma*maxQ(s') - Q) in 18-bit two's complement, and
//   writes the updated row back with only the selected lane replaced.
//   Q-values and rewards are 16-bit sign-magnitude (bit 15 = sign).
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                one-cycle request, sampled only while idle
//   state, next_state    s and s' (row addresses)
//   action               1..4 selects lane [15:0]..[63:48]; others invalid
//   reward, terminal     reward r (sign-magnitude); terminal forces maxQ=0
//   busy, done, err      status: busy after accept through DONE, done pulse,
//                        sticky invalid-action flag
//   mem_addr, mem_rd_en, mem_rd_data, mem_wr_en, mem_wr_data
//                        Q-table port; read data valid one cycle after strobe
//   upd_count, sat_count (only with Q_UPDATE_STATS_EN) write / saturation
//                        counters, 16-bit wrapping
//
// Optional feature macro: Q_UPDATE_STATS_EN
module q_table_updater #(
  parameter int unsigned STATE_W     = 4,
  parameter int unsigned ALPHA_SHIFT = 1,
  parameter int unsigned GAMMA_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [STATE_W-1:0] state,
  input  logic [STATE_W-1:0] next_state,
  input  logic [3:0]         action,
  input  logic [15:0]        reward,
  input  logic               terminal,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [STATE_W-1:0] mem_addr,
  output logic               mem_rd_en,
  input  logic [63:0]        mem_rd_data,
  output logic               mem_wr_en,
  output logic [63:0]        mem_wr_data
`ifdef Q_UPDATE_STATS_EN
  ,
  output logic [15:0]        upd_count,
  output logic [15:0]        sat_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CUR, S_RD_NXT, S_MAXQ, S_CALC, S_WRITE, S_DONE
  } state_e;

  localparam logic signed [17:0] Q_MAX = 18'sd32767;

  state_e state_q, state_d;

  logic [STATE_W-1:0] s_q, s_d, ns_q, ns_d;
  logic [3:0]         action_q, action_d;
  logic [15:0]        reward_q, reward_d;
  logic               terminal_q, terminal_d;
  logic               err_q, err_d;
  logic [63:0]        cur_row_q, cur_row_d;
  logic signed [17:0] maxq_q, maxq_d;
  logic [15:0]        new_lane_q, new_lane_d;

  function automatic logic signed [17:0] sm_to_tc(input logic [15:0] v);
    logic signed [17:0] m;
    m = {3'b000, v[14:0]};
    return v[15] ? -m : m;
  endfunction

  function automatic logic act_valid(input logic [3:0] a);
    return (a != 4'd0) && (a <= 4'd4);
  endfunction

  logic               valid_q;
  logic [1:0]         lane_sel;
  logic [15:0]        q_lane;
  logic signed [17:0] lane_tc [4];
  logic signed [17:0] row_max;
  logic signed [17:0] q_tc, r_tc, g, t, dlt, n, n_abs;
  logic               calc_sat;
  logic [14:0]        mag_sat;
  logic [15:0]        calc_lane;
  logic [63:0]        wr_row;

  assign valid_q  = act_valid(action_q);
  assign lane_sel = 2'(action_q - 4'd1);
  assign q_lane   = cur_row_q[16*lane_sel +: 16];

  // Signed max over the next-state row; -0 converts to 0 so it ties with +0.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      lane_tc[i] = sm_to_tc(mem_rd_data[16*i +: 16]);
    end
    row_max = lane_tc[0];
    for (int unsigned i = 1; i < 4; i++) begin
      if (lane_tc[i] > row_max) row_max = lane_tc[i];
    end
  end

  // Update arithmetic; 18 bits cover the worst-case intermediate range.
  always_comb begin
    q_tc     = sm_to_tc(q_lane);
    r_tc     = sm_to_tc(reward_q);
    g        = maxq_q - (maxq_q >>> GAMMA_SHIFT);
    t        = r_tc + g;
    dlt      = t - q_tc;
    n        = q_tc + (dlt >>> ALPHA_SHIFT);
    // Saturation is symmetric, so clamp the magnitude and keep the sign;
    // a negative n always has a non-zero magnitude, so zero stays 0x0000.
    n_abs    = n[17] ? -n : n;
    calc_sat = (n_abs > Q_MAX);
    mag_sat  = calc_sat ? 15'h7FFF : n_abs[14:0];
    calc_lane = {n[17], mag_sat};
  end

  always_comb begin
    wr_row = cur_row_q;
    wr_row[16*lane_sel +: 16] = new_lane_q;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_RD_CUR;
      S_RD_CUR: state_d = S_RD_NXT;
      S_RD_NXT: state_d = S_MAXQ;
      S_MAXQ:   state_d = S_CALC;
      S_CALC:   state_d = S_WRITE;
      S_WRITE:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    err         = err_q;
    mem_addr    = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state_q)
      S_RD_CUR: begin mem_rd_en = 1'b1; mem_addr = s_q;  end
      S_RD_NXT: begin mem_rd_en = 1'b1; mem_addr = ns_q; end
      S_WRITE: if (valid_q) begin
        mem_wr_en   = 1'b1;
        mem_addr    = s_q;
        mem_wr_data = wr_row;
      end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  // Datapath next values
  always_comb begin
    s_d        = s_q;
    ns_d       = ns_q;
    action_d   = action_q;
    reward_d   = reward_q;
    terminal_d = terminal_q;
    err_d      = err_q;
    cur_row_d  = cur_row_q;
    maxq_d     = maxq_q;
    new_lane_d = new_lane_q;
    case (state_q)
      S_IDLE: if (start) begin
        s_d        = state;
        ns_d       = next_state;
        action_d   = action;
        reward_d   = reward;
        terminal_d = terminal;
        err_d      = !act_valid(action);
      end
      S_RD_NXT: cur_row_d  = mem_rd_data;
      S_MAXQ:   maxq_d     = terminal_q ? '0 : row_max;
      S_CALC:   new_lane_d = calc_lane;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= '0;
      ns_q       <= '0;
      action_q   <= '0;
      reward_q   <= '0;
      terminal_q <= 1'b0;
      err_q      <= 1'b0;
      cur_row_q  <= '0;
      maxq_q     <= '0;
      new_lane_q <= '0;
    end else begin
      s_q        <= s_d;
      ns_q       <= ns_d;
      action_q   <= action_d;
      reward_q   <= reward_d;
      terminal_q <= terminal_d;
      err_q      <= err_d;
      cur_row_q  <= cur_row_d;
      maxq_q     <= maxq_d;
      new_lane_q <= new_lane_d;
    end
  end

`ifdef Q_UPDATE_STATS_EN
  logic [15:0] upd_count_q, upd_count_d, sat_count_q, sat_count_d;

  always_comb begin
    upd_count_d = upd_count_q;
    sat_count_d = sat_count_q;
    if (state_q == S_WRITE && valid_q)            upd_count_d = upd_count_q + 16'd1;
    if (state_q == S_CALC && valid_q && calc_sat) sat_count_d = sat_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_count_q <= '0;
      sat_count_q <= '0;
    end else begin
      upd_count_q <= upd_count_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign upd_count = upd_count_q;
  assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_q_table_updater.sv
module tb_q_table_updater;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  state, next_state, action;
  logic [15:0] reward;
  logic        terminal;
  logic        busy, done, err;
  logic [3:0]  mem_addr;
  logic        mem_rd_en, mem_wr_en;
  logic [63:0] mem_rd_data, mem_wr_data;
`ifdef Q_UPDATE_STATS_EN
  logic [15:0] upd_count, sat_count;
  int          exp_upd = 0, exp_satc = 0;
`endif

  int checks = 0;
  int errors = 0;

  q_table_updater #(.STATE_W(4), .ALPHA_SHIFT(1), .GAMMA_SHIFT(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .state(state),
    .next_state(next_state), .action(action), .reward(reward),
    .terminal(terminal), .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
`ifdef Q_UPDATE_STATS_EN
    , .upd_count(upd_count), .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: synchronous read, data valid the cycle after the strobe.
  logic [63:0] mem [16];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] data;
  } wr_exp_t;
  wr_exp_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_wr_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {60'd0, mem_addr}, 64'hDEAD);
      end else begin
        wr_exp_t e;
        e = sb_q.pop_front();
        chk("wr_addr", {60'd0, mem_addr}, {60'd0, e.addr});
        chk("wr_data", mem_wr_data, e.data);
      end
    end
  end

  // Independent reference of the update rule in plain integers.
  function automatic int sm2i(input logic [15:0] v);
    return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
  endfunction

  function automatic int fdiv(input int x, input int d);
    int q;
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [16:0] model(input logic [63:0] cur, input logic [63:0] nxt,
                                        input logic [3:0] act, input logic [15:0] r,
                                        input logic term);
    int m, q, g, d, n, lv;
    logic sat;
    logic [15:0] lane;
    m = 0;
    if (!term) begin
      m = -100000;
      for (int i = 0; i < 4; i++) begin
        lv = sm2i(nxt[16*i +: 16]);
        if (lv > m) m = lv;
      end
    end
    q = sm2i(cur[16*(int'(act)-1) +: 16]);
    g = m - fdiv(m, 8);
    d = sm2i(r) + g - q;
    n = q + fdiv(d, 2);
    sat = 1'b0;
    if (n > 32767)  begin n = 32767;  sat = 1'b1; end
    if (n < -32767) begin n = -32767; sat = 1'b1; end
    lane = (n < 0) ? {1'b1, 15'(-n)} : {1'b0, 15'(n)};
    return {sat, lane};
  endfunction

  // One transaction with per-cycle protocol checks. Cycle 0 = accept cycle.
  task automatic run_txn(input logic [3:0] s, input logic [3:0] ns, input logic [3:0] act,
                         input logic [15:0] r, input logic term, input bit exp_err,
                         input bit dup);
    logic [3:0] ea;
    @(posedge clk); #1;
    state = s; next_state = ns; action = act; reward = r; terminal = term; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      ea = (k == 1) ? s : (k == 2) ? ns : (k == 5 && !exp_err) ? s : 4'd0;
      chk($sformatf("busy_c%0d", k), {63'd0, busy}, {63'd0, (k <= 6)});
      chk($sformatf("rd_en_c%0d", k), {63'd0, mem_rd_en}, {63'd0, (k == 1 || k == 2)});
      chk($sformatf("wr_en_c%0d", k), {63'd0, mem_wr_en}, {63'd0, (k == 5 && !exp_err)});
      chk($sformatf("done_c%0d", k), {63'd0, done}, {63'd0, (k == 6)});
      chk($sformatf("addr_c%0d", k), {60'd0, mem_addr}, {60'd0, ea});
      chk($sformatf("err_c%0d", k), {63'd0, err}, {63'd0, exp_err});
      if (dup && k == 2) begin start = 1'b1; state = ~s; action = 4'd1; end
      if (dup && k == 3) start = 1'b0;
    end
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [3:0]  s, ns, act;
    logic [15:0] r;
    logic        term;
    logic [63:0] cur, nxt;
    logic [15:0] exp_lane;
    bit          exp_err;
    bit          exp_sat;
  } vec_t;

  vec_t vecs[10];

  task automatic apply_vec(input vec_t v, input bit dup);
    logic [63:0] wr;
    mem[v.s]  = v.cur;
    mem[v.ns] = v.nxt;
    if (!v.exp_err) begin
      wr = v.cur;
      wr[16*(int'(v.act)-1) +: 16] = v.exp_lane;
      sb_q.push_back('{addr: v.s, data: wr});
`ifdef Q_UPDATE_STATS_EN
      exp_upd++;
      if (v.exp_sat) exp_satc++;
`endif
    end
    run_txn(v.s, v.ns, v.act, v.r, v.term, v.exp_err, dup);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t rv;
    logic [16:0] mres;

    vecs[0] = '{4'd2,  4'd3,  4'd1, 16'h0064, 1'b0, 64'h0,
                64'h0000_0000_0320_0000, 16'h0190, 1'b0, 1'b0};
    vecs[1] = '{4'd5,  4'd6,  4'd3, 16'h8064, 1'b1, 64'h1111_0000_2222_3333,
                64'h7FFF_7FFF_7FFF_7FFF, 16'h8032, 1'b0, 1'b0};
    vecs[2] = '{4'd14, 4'd15, 4'd0, 16'h0064, 1'b0, 64'h1, 64'h2, 16'h0, 1'b1, 1'b0};
    vecs[3] = '{4'd7,  4'd8,  4'd4, 16'h7FFF, 1'b0, 64'h7D00_0001_0002_0003,
                64'h0000_7FFF_8005_0001, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{4'd1,  4'd0,  4'd7, 16'h0010, 1'b0, 64'h5, 64'h6, 16'h0, 1'b1, 1'b0};
    vecs[5] = '{4'd9,  4'd10, 4'd2, 16'h0000, 1'b0, 64'hAAAA_0BBB_0000_0CCC,
                64'h0003_8000_0005_8010, 16'h0002, 1'b0, 1'b0};
    vecs[6] = '{4'd4,  4'd4,  4'd1, 16'h0000, 1'b0, 64'h0000_0000_0000_0100,
                64'h0000_0000_0000_0100, 16'h00F0, 1'b0, 1'b0};
    vecs[7] = '{4'd11, 4'd12, 4'd1, 16'h0001, 1'b1, 64'h0000_0000_0000_8001,
                64'h1234_1234_1234_1234, 16'h0000, 1'b0, 1'b0};
    vecs[8] = '{4'd12, 4'd13, 4'd2, 16'hFFFF, 1'b0, 64'h0000_0000_FFFF_0000,
                64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 1'b0, 1'b1};
    vecs[9] = '{4'd3,  4'd2,  4'd2, 16'h0100, 1'b0, 64'h0000_0000_8040_0000,
                64'h0000_0000_0000_0000, 16'h0060, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) mem[i] = 64'h0;
    rst_n = 1'b0; start = 1'b0; state = '0; next_state = '0; action = '0;
    reward = '0; terminal = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
    chk("rst_wr_en", {63'd0, mem_wr_en}, 64'd0);
    chk("rst_addr", {60'd0, mem_addr}, 64'd0);
    chk("rst_wr_data", mem_wr_data, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) apply_vec(vecs[i], 1'b0);

    // Start while busy is ignored.
    apply_vec(vecs[0], 1'b1);

    // Randomised updates against the integer reference.
    for (int i = 0; i < 12; i++) begin
      rv.s    = 4'($urandom_range(0, 15));
      rv.ns   = 4'($urandom_range(0, 15));
      rv.act  = 4'($urandom_range(1, 4));
      rv.r    = 16'($urandom);
      rv.term = 1'($urandom_range(0, 1));
      rv.nxt  = {$urandom, $urandom};
      rv.cur  = (rv.s == rv.ns) ? rv.nxt : {$urandom, $urandom};
      mres    = model(rv.cur, rv.nxt, rv.act, rv.r, rv.term);
      rv.exp_lane = mres[15:0];
      rv.exp_sat  = mres[16];
      rv.exp_err  = 1'b0;
      apply_vec(rv, 1'b0);
    end

    // Reset during CALC aborts with no write.
    mem[6] = 64'h0; mem[7] = 64'h0000_0000_0000_0100;
    @(posedge clk); #1;
    state = 4'd6; next_state = 4'd7; action = 4'd1; reward = 16'h0100; terminal = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_err", {63'd0, err}, 64'd0);
    chk("abort_rd_en", {63'd0, mem_rd_en}, 64'd0);
    chk("abort_wr_en", {63'd0, mem_wr_en}, 64'd0);
    chk("abort_addr", {60'd0, mem_addr}, 64'd0);
`ifdef Q_UPDATE_STATS_EN
    chk("abort_upd_count", {48'd0, upd_count}, 64'd0);
    exp_upd = 0; exp_satc = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("abort_hold_wr_en", {63'd0, mem_wr_en}, 64'd0);
    rst_n = 1'b1;
    apply_vec(vecs[5], 1'b0);
    apply_vec(vecs[3], 1'b0);

`ifdef Q_UPDATE_STATS_EN
    chk("upd_count", {48'd0, upd_count}, 64'(exp_upd));
    chk("sat_count", {48'd0, sat_count}, 64'(exp_satc));
`endif

    chk("sb_final", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/q_table_updater.md
Name: q_table_updater

Overview:
- Writer-side companion to the Q-value action selector in the maze Q-learning core.
- After an action is taken, it reads the current-state row and the next-state row from the Q-table memory.
- It applies Q(s,a) <= Q + alpha*(r + gamma*maxQ(s') - Q) and writes the updated row back.
- Q-values and rewards are 16-bit sign-magnitude: bit 15 is the sign, bits 14:0 the magnitude. This is the format the selector consumes.

Parameters:
- STATE_W, 4, state/address width (2^STATE_W table rows).
- ALPHA_SHIFT, 1, alpha = 2^-ALPHA_SHIFT.
- GAMMA_SHIFT, 3, gamma = 1 - 2^-GAMMA_SHIFT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- state  in  STATE_W  state s in which the action was taken.
- next_state  in  STATE_W  resulting state s'.
- action  in  4  1..4; selects lane [15:0], [31:16], [47:32], [63:48] respectively.
- reward  in  16  sign-magnitude reward r.
- terminal  in  1  s' is terminal; maxQ(s') is forced to 0.
- busy  out  1  high from the cycle after start is accepted through DONE.
- done  out  1  one-cycle pulse at completion.
- err  out  1  sticky; set on an invalid action; cleared by the next accepted start.
- mem_addr  out  STATE_W  Q-table row address.
- mem_rd_en  out  1  read strobe; data is valid on mem_rd_data the next cycle.
- mem_rd_data  in  64  row read data.
- mem_wr_en  out  1  write strobe.
- mem_wr_data  out  64  full row write data.

Behaviour:
- Reset: all outputs 0; FSM in IDLE. An rst_n assertion mid-operation aborts immediately; no write is issued.
- IDLE: on start=1, latch state, next_state, action, reward and terminal; clear err; go to RD_CUR. A start while busy is ignored.
- RD_CUR (1 cycle): mem_rd_en=1, mem_addr=state.
- RD_NXT (1 cycle): mem_rd_en=1, mem_addr=next_state; latch mem_rd_data as cur_row.
- MAXQ (1 cycle): latch mem_rd_data as nxt_row; compute the signed max of its four lanes into maxq; -0 equals +0. terminal=1 forces maxq=0.
- CALC (1 cycle):
  - Convert the selected lane Q, reward and maxq to 18-bit two's complement.
  - g = maxq - (maxq >>> GAMMA_SHIFT).
  - t = r + g.
  - d = t - Q.
  - n = Q + (d >>> ALPHA_SHIFT).
  - All shifts are arithmetic (floor).
  - Saturate n to [-32767, +32767]; convert back to sign-magnitude; zero is always encoded 0x0000.
- WRITE (1 cycle): mem_wr_en=1, mem_addr=state, mem_wr_data = cur_row with only the selected lane replaced.
- DONE (1 cycle): done=1; return to IDLE.
- Latency: start accepted in cycle 0; write in cycle 5; done in cycle 6. A new start is accepted in cycle 7.
- Invalid action (0 or >4): the read cycles still run; WRITE is suppressed (mem_wr_en stays 0); err=1; done still pulses in cycle 6.
- state == next_state is legal: both reads return the pre-update row.
- Read and write strobes are never high in the same cycle; mem_addr=0 when no strobe is active.

Optional Feature:
- Macro Q_UPDATE_STATS_EN.
- When defined, add two outputs:
  - upd_count[15:0]: increments on every issued write.
  - sat_count[15:0]: increments when CALC saturated.
  - Both counters wrap at 0xFFFF -> 0 and reset to 0.
- When undefined, neither port nor logic exists; all other behaviour is identical.

Test Plan:
- Basic update: row s=2 all 0; s'=3 row {0, 800, 0, 0}; action=1; r=0x0064 -> write to addr 2 in cycle 5, lane0=0x0190 (400), other lanes unchanged; done in cycle 6.
- Negative/terminal: Q=0, r=0x8064 (-100), terminal=1, action=3 -> lane2=0x8032 (-50); nxt_row ignored.
- Saturation: Q=32000, r=0x7FFF, maxQ=32767, action=4 -> lane3=0x7FFF; sat_count increments when the macro is defined.
- Mixed-sign max: s' row {0x8010, 0x0005, 0x8000, 0x0003} -> maxq=+5; Q=0, r=0, action=2 -> g=5-0=5, lane1=0x0002 (floor of 5/2).
- Invalid action: action=0 -> no mem_wr_en; err=1; done in cycle 6; the next valid start clears err.
- Protocol: start while busy is ignored; rst_n pulled low in CALC -> all outputs 0 and no write; a start after reset completes normally.
